// File: rtl/fifo_sync_param_pkg.sv
// Shared widths and parameter legality helper for the synchronous show-ahead FIFO.
package fifo_sync_param_pkg;

  localparam int CORE_BW   = 4;
  localparam int CORE_SIMD = 1;

  // Depth must be a power of two >= 2; thresholds must sit inside the occupancy range.
  function automatic bit fifo_params_legal(int depth, int af_lvl, int ae_lvl);
    return (depth >= 2) && ((depth & (depth - 1)) == 0) &&
           (af_lvl >= 1) && (af_lvl <= depth) &&
           (ae_lvl >= 0) && (ae_lvl <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_mux_n_1.sv
// depth:1 word selector over a flat storage vector; drives the FIFO head word.
module fifo_mux_n_1
  import fifo_sync_param_pkg::*;
#(
  parameter int bw    = CORE_BW,
  parameter int simd  = CORE_SIMD,
  parameter int depth = 8
) (
  input  logic [depth*bw*simd-1:0] data,
  input  logic [$clog2(depth)-1:0] sel,
  output logic [bw*simd-1:0]       out
);

  localparam int W  = bw * simd;
  localparam int AW = $clog2(depth);

  always_comb begin
    out = '0;
    for (int i = 0; i < depth; i++) begin
      if (sel == AW'(i)) out = data[i*W +: W];
    end
  end

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock show-ahead FIFO with occupancy count, threshold flags and sticky error flags.
module fifo_sync_param
  import fifo_sync_param_pkg::*;
#(
  parameter int bw     = CORE_BW,
  parameter int simd   = CORE_SIMD,
  parameter int depth  = 8,
  parameter int af_lvl = 6,
  parameter int ae_lvl = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr,
  input  logic [bw*simd-1:0]         in,
  input  logic                       rd,
  output logic [bw*simd-1:0]         out,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_afull,
  output logic                       o_aempty,
  output logic [$clog2(depth):0]     o_count,
  output logic                       o_ovf,
  output logic                       o_udf,
  input  logic                       clr_err
);

  localparam int W  = bw * simd;
  localparam int AW = $clog2(depth);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(depth);
  localparam logic [AW:0] AF_C    = (AW+1)'(af_lvl);
  localparam logic [AW:0] AE_C    = (AW+1)'(ae_lvl);

  generate
    if (!fifo_params_legal(depth, af_lvl, ae_lvl)) begin : g_bad_params
      $error("fifo_sync_param: illegal depth/af_lvl/ae_lvl combination");
    end
  endgenerate

  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [AW:0]        count;
  logic [W-1:0]       mem [depth];
  logic [depth*W-1:0] mem_flat;
  logic [W-1:0]       head;
  logic               push_ok;
  logic               pop_ok;

  // Flags come only from the registered count, so wr/rd never reach them combinationally.
  assign o_count  = count;
  assign o_full   = (count == DEPTH_C);
  assign o_empty  = (count == '0);
  assign o_afull  = (count >= AF_C);
  assign o_aempty = (count <= AE_C);

  // A full FIFO still accepts a write when the same cycle frees a slot.
  assign push_ok = wr & (~o_full | rd);
  assign pop_ok  = rd & ~o_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      o_ovf  <= 1'b0;
      o_udf  <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // Set wins over clear when both happen in the same cycle.
      if (wr & o_full & ~rd) o_ovf <= 1'b1;
      else if (clr_err)      o_ovf <= 1'b0;
      if (rd & o_empty)      o_udf <= 1'b1;
      else if (clr_err)      o_udf <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wr_ptr[AW-1:0]] <= in;
  end

  always_comb begin
    for (int i = 0; i < depth; i++) mem_flat[i*W +: W] = mem[i];
  end

  fifo_mux_n_1 #(
    .bw    (bw),
    .simd  (simd),
    .depth (depth)
  ) u_mux (
    .data (mem_flat),
    .sel  (rd_ptr[AW-1:0]),
    .out  (head)
  );

  assign out = o_empty ? '0 : head;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Randomised and directed bench for fifo_sync_param with a queue-based reference model.
module tb_fifo_sync_param;

  localparam int BW    = 4;
  localparam int SIMD  = 1;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 2;
  localparam int W     = BW * SIMD;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset;
  logic          wr;
  logic [W-1:0]  din;
  logic          rd;
  logic [W-1:0]  dout;
  logic          o_full, o_empty, o_afull, o_aempty, o_ovf, o_udf;
  logic [AW:0]   o_count;
  logic          clr_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: contents in arrival order plus the two sticky flags.
  logic [W-1:0] mq[$];
  bit           m_ovf = 0;
  bit           m_udf = 0;
  bit           started = 0;

  fifo_sync_param #(
    .bw(BW), .simd(SIMD), .depth(DEPTH), .af_lvl(AF), .ae_lvl(AE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .in       (din),
    .rd       (rd),
    .out      (dout),
    .o_full   (o_full),
    .o_empty  (o_empty),
    .o_afull  (o_afull),
    .o_aempty (o_aempty),
    .o_count  (o_count),
    .o_ovf    (o_ovf),
    .o_udf    (o_udf),
    .clr_err  (clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: one FIFO transaction per rising edge, from the queue's own size.
  always @(posedge clk) begin
    bit full, empty, do_pop, do_push;
    started <= 1'b1;
    if (reset) begin
      mq.delete();
      m_ovf = 0;
      m_udf = 0;
    end else begin
      full    = (mq.size() == DEPTH);
      empty   = (mq.size() == 0);
      do_pop  = rd && !empty;
      do_push = wr && (!full || rd);
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(din);
      if (wr && full && !rd) m_ovf = 1;
      else if (clr_err)      m_ovf = 0;
      if (rd && empty)       m_udf = 1;
      else if (clr_err)      m_udf = 0;
    end
  end

  // Monitor: mid-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (started) begin
      int n;
      n = mq.size();
      chk("count",  32'(o_count),  32'(n));
      chk("empty",  32'(o_empty),  32'(n == 0));
      chk("full",   32'(o_full),   32'(n == DEPTH));
      chk("afull",  32'(o_afull),  32'(n >= AF));
      chk("aempty", 32'(o_aempty), 32'(n <= AE));
      chk("head",   32'(dout),     (n > 0) ? 32'(mq[0]) : 32'd0);
      chk("ovf",    32'(o_ovf),    32'(m_ovf));
      chk("udf",    32'(o_udf),    32'(m_udf));
    end
  end

  task automatic step(input logic w, input logic r, input logic c, input logic [W-1:0] d);
    wr = w; rd = r; clr_err = c; din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; wr = 1'b1; rd = 1'b1; din = 4'h3; clr_err = 1'b0;

    // Reset with wr/rd asserted must not take a push.
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_count", 32'(o_count), 32'd0);
    chk("rst_empty", 32'(o_empty), 32'd1);
    chk("rst_out",   32'(dout),    32'd0);
    chk("rst_full",  32'(o_full),  32'd0);
    reset = 1'b0;

    // Fill to full.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b0, 1'b0, W'(i));
      if (i == 5) chk("afull_at5", 32'(o_afull), 32'd0);
      if (i == 6) chk("afull_at6", 32'(o_afull), 32'd1);
    end
    chk("full_at8", 32'(o_full), 32'd1);

    // Overflow, then clear, then clear racing a new overflow.
    step(1'b1, 1'b0, 1'b0, 4'h9);
    chk("ovf_set",    32'(o_ovf),   32'd1);
    chk("ovf_count",  32'(o_count), 32'd8);
    step(1'b0, 1'b0, 1'b1, 4'h0);
    chk("ovf_clr",    32'(o_ovf),   32'd0);
    step(1'b1, 1'b0, 1'b1, 4'h9);
    chk("ovf_setwin", 32'(o_ovf),   32'd1);
    step(1'b0, 1'b0, 1'b1, 4'h0);
    chk("ovf_clr2",   32'(o_ovf),   32'd0);

    // Full + rd + wr: both accepted.
    chk("t3_head", 32'(dout), 32'h1);
    step(1'b1, 1'b1, 1'b0, 4'hA);
    chk("t3_count", 32'(o_count), 32'd8);
    chk("t3_ovf",   32'(o_ovf),   32'd0);
    chk("t3_head2", 32'(dout),    32'h2);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("t3_last", 32'(dout), 32'hA);
      step(1'b0, 1'b1, 1'b0, 4'h0);
    end
    chk("drain_empty", 32'(o_empty), 32'd1);

    // Empty + rd + wr: underflow flagged, push still taken.
    step(1'b1, 1'b1, 1'b0, 4'h5);
    chk("t4_udf",   32'(o_udf),   32'd1);
    chk("t4_count", 32'(o_count), 32'd1);
    chk("t4_out",   32'(dout),    32'h5);
    step(1'b0, 1'b0, 1'b1, 4'h0);
    chk("udf_clr",  32'(o_udf),   32'd0);

    // Random traffic, first push-heavy, then pop-heavy, to cross full/empty and wrap.
    for (int i = 0; i < 80; i++) begin
      int pw;
      pw = (i < 40) ? 70 : 35;
      step(1'($urandom_range(0, 99) < pw),
           1'($urandom_range(0, 99) < (100 - pw)),
           1'($urandom_range(0, 99) < 10),
           W'($urandom));
    end

    step(1'b0, 1'b0, 1'b0, 4'h0);
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
